inverter4bit_checker: RTL and testbench

- Self-checking response monitor for the 4-bit inverter datapath; the receiving end of the inverter stimulus stream.
- Samples each applied input/output vector pair, compares the output against the bitwise inverse of the input, and counts mismatches.
- Reports pass/fail and captures the first failing pair.
- Sits beside the inverter in hardware test builds and replaces manual waveform inspection.

---
 rtl/inverter4bit_checker_if.sv | 29 ++
 rtl/inverter4bit_checker.sv | 121 ++++++++++++
 tb/tb_inverter4bit_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/inverter4bit_checker_if.sv
// Stimulus/response bundle between an inverter test harness and its response checker.
// The checker takes the slave view; the harness driving the DUT takes the master view.
interface inverter4bit_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             vec_valid;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] A_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] first_err_in;
  logic [WIDTH-1:0] first_err_out;

  modport master (
    output start, num_vec, vec_valid, A_in, A_out,
    input  busy, done, pass, vec_cnt, err_cnt, first_err_in, first_err_out
  );

  modport slave (
    input  start, num_vec, vec_valid, A_in, A_out,
    output busy, done, pass, vec_cnt, err_cnt, first_err_in, first_err_out
  );
endinterface

// File: rtl/inverter4bit_checker.sv
// Response checker for an inverter datapath: compares A_out against ~A_in delayed by LAT
// clocks, counts vectors and mismatches, and records the first failing pair.
module inverter4bit_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  inverter4bit_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] num_reg, num_next;
  logic [CNT_W-1:0] vec_cnt_reg, vec_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [WIDTH-1:0] first_in_reg, first_in_next;
  logic [WIDTH-1:0] first_out_reg, first_out_next;

  logic             in_run;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_in;
  logic             mismatch;

  assign in_run = (state_reg == RUN);

  // The delayed A_in (not just its inverse) is carried so the first failing input can be reported.
  generate
    if (LAT == 0) begin : g_comb
      assign cmp_in    = bus.A_in;
      assign cmp_valid = bus.vec_valid & in_run;
    end else begin : g_pipe
      logic [WIDTH-1:0] in_pipe_reg [LAT];
      logic [LAT-1:0]   val_pipe_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_pipe_reg <= '0;
          for (int i = 0; i < LAT; i++) in_pipe_reg[i] <= '0;
        end else begin
          in_pipe_reg[0]  <= bus.A_in;
          val_pipe_reg[0] <= bus.vec_valid & in_run;
          for (int i = 1; i < LAT; i++) begin
            in_pipe_reg[i]  <= in_pipe_reg[i-1];
            val_pipe_reg[i] <= val_pipe_reg[i-1];
          end
        end
      end

      assign cmp_in    = in_pipe_reg[LAT-1];
      assign cmp_valid = val_pipe_reg[LAT-1];
    end
  endgenerate

  assign mismatch = (bus.A_out != ~cmp_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      num_reg       <= '0;
      vec_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      first_in_reg  <= '0;
      first_out_reg <= '0;
    end else begin
      state_reg     <= state_next;
      num_reg       <= num_next;
      vec_cnt_reg   <= vec_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      first_in_reg  <= first_in_next;
      first_out_reg <= first_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    num_next       = num_reg;
    vec_cnt_next   = vec_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    first_in_next  = first_in_reg;
    first_out_next = first_out_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          num_next       = bus.num_vec;
          vec_cnt_next   = '0;
          err_cnt_next   = '0;
          first_in_next  = '0;
          first_out_next = '0;
          state_next     = (bus.num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cmp_valid) begin
          vec_cnt_next = vec_cnt_reg + 1'b1;
          if (mismatch) begin
            // err_cnt saturates, so zero reliably marks "no mismatch yet in this run".
            if (err_cnt_reg == '0) begin
              first_in_next  = cmp_in;
              first_out_next = bus.A_out;
            end
            if (err_cnt_reg != CNT_MAX) err_cnt_next = err_cnt_reg + 1'b1;
          end
          if (vec_cnt_next == num_reg) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy          = in_run;
  assign bus.done          = (state_reg == DONE);
  assign bus.pass          = (state_reg == DONE) && (err_cnt_reg == '0);
  assign bus.vec_cnt       = vec_cnt_reg;
  assign bus.err_cnt       = err_cnt_reg;
  assign bus.first_err_in  = first_in_reg;
  assign bus.first_err_out = first_out_reg;
endmodule

// File: tb/tb_inverter4bit_checker.sv
// Bench for inverter4bit_checker: three instances (LAT=0, LAT=2, CNT_W=2) share one stimulus
// stream; expectations come from a vector-list model of the checking rules.
module tb_inverter4bit_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int         sel = 0;
  logic       start = 1'b0;
  logic [7:0] num_vec = '0;
  logic       vec_valid = 1'b0;
  logic [3:0] a_in = 4'h5;
  logic [3:0] a_bad = '0;
  logic       one_stage = 1'b0;
  logic [3:0] r1 = '0;
  logic [3:0] r2 = '0;

  int checks = 0;
  int failures = 0;

  inverter4bit_checker_if #(.WIDTH(4), .CNT_W(8)) b0();
  inverter4bit_checker_if #(.WIDTH(4), .CNT_W(8)) b2();
  inverter4bit_checker_if #(.WIDTH(4), .CNT_W(2)) bs();

  inverter4bit_checker #(.WIDTH(4), .LAT(0), .CNT_W(8)) u_lat0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  inverter4bit_checker #(.WIDTH(4), .LAT(2), .CNT_W(8)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  inverter4bit_checker #(.WIDTH(4), .LAT(0), .CNT_W(2)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bs));

  // Behavioural DUT for the LAT=2 checker: two register stages, or one when one_stage is set.
  always @(posedge clk) begin
    r1 <= ~a_in;
    r2 <= r1;
  end

  assign b0.start = start && (sel == 0);
  assign b0.num_vec = num_vec;
  assign b0.vec_valid = vec_valid;
  assign b0.A_in = a_in;
  assign b0.A_out = ~a_in ^ a_bad;

  assign b2.start = start && (sel == 1);
  assign b2.num_vec = num_vec;
  assign b2.vec_valid = vec_valid;
  assign b2.A_in = a_in;
  assign b2.A_out = one_stage ? r1 : r2;

  assign bs.start = start && (sel == 2);
  assign bs.num_vec = num_vec[1:0];
  assign bs.vec_valid = vec_valid;
  assign bs.A_in = a_in;
  assign bs.A_out = ~a_in ^ a_bad;

  logic       o_busy, o_done, o_pass;
  logic [7:0] o_vc, o_ec;
  logic [3:0] o_fi, o_fo;

  always_comb begin
    o_busy = b0.busy; o_done = b0.done; o_pass = b0.pass;
    o_vc = b0.vec_cnt; o_ec = b0.err_cnt; o_fi = b0.first_err_in; o_fo = b0.first_err_out;
    if (sel == 1) begin
      o_busy = b2.busy; o_done = b2.done; o_pass = b2.pass;
      o_vc = b2.vec_cnt; o_ec = b2.err_cnt; o_fi = b2.first_err_in; o_fo = b2.first_err_out;
    end else if (sel == 2) begin
      o_busy = bs.busy; o_done = bs.done; o_pass = bs.pass;
      o_vc = {6'b0, bs.vec_cnt}; o_ec = {6'b0, bs.err_cnt};
      o_fi = bs.first_err_in; o_fo = bs.first_err_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit         stim_v[$];
  logic [3:0] stim_in[$];
  logic [3:0] stim_bad[$];

  task automatic add(input bit v, input logic [3:0] vin, input logic [3:0] bad);
    stim_v.push_back(v);
    stim_in.push_back(vin);
    stim_bad.push_back(bad);
  endtask

  // Runs one check on instance s with num_vec=n; k is the stage count of the LAT=2 DUT.
  task automatic run_check(input string tag, input int s, input int n, input int k);
    int lat = (s == 1) ? 2 : 0;
    int cnt_max = (s == 2) ? 3 : 255;
    int len = stim_v.size();
    logic [3:0] fill = 4'h5;
    logic [3:0] seq[$];
    int vtimes[$];
    int e_vc = 0;
    int e_ec = 0;
    logic [3:0] e_fi = '0;
    logic [3:0] e_fo = '0;
    logic [3:0] vin, vout;

    // seq[j] is A_in applied at cycle j; cycle 0 is the start cycle.
    seq.push_back(fill);
    for (int i = 0; i < len; i++) seq.push_back(stim_in[i]);
    for (int i = 0; i < 6; i++) seq.push_back(fill);

    for (int i = 0; i < len; i++) begin
      if (stim_v[i]) begin
        vin = seq[i+1];
        vout = (lat == 0) ? (~seq[i+1] ^ stim_bad[i]) : ~seq[i+3-k];
        if (vtimes.size() < n) begin
          e_vc++;
          if (vout != ~vin) begin
            if (e_ec == 0) begin
              e_fi = vin;
              e_fo = vout;
            end
            if (e_ec < cnt_max) e_ec++;
          end
        end
        vtimes.push_back(i + 1);
      end
    end

    sel = s;
    one_stage = (k == 1);
    @(negedge clk);
    start = 1'b1; num_vec = n[7:0]; vec_valid = 1'b0; a_in = fill; a_bad = '0;
    for (int j = 1; j <= len + 4; j++) begin
      int ready = 0;
      bit exp_done;
      @(negedge clk);
      foreach (vtimes[q]) if (vtimes[q] + lat < j) ready++;
      exp_done = (ready >= n);
      check({tag, "_done"}, o_done, exp_done);
      check({tag, "_busy"}, o_busy, !exp_done);
      check({tag, "_pass"}, o_pass, exp_done && (e_ec == 0));
      start = 1'b0;
      if (j <= len) begin
        vec_valid = stim_v[j-1]; a_in = stim_in[j-1]; a_bad = stim_bad[j-1];
      end else begin
        vec_valid = 1'b0; a_in = fill; a_bad = '0;
      end
    end
    @(negedge clk);
    check({tag, "_vec_cnt"}, o_vc, e_vc);
    check({tag, "_err_cnt"}, o_ec, e_ec);
    check({tag, "_first_in"}, o_fi, e_fi);
    check({tag, "_first_out"}, o_fo, e_fo);
    $display("run %s inst=%0d n=%0d vec_cnt=%0d err_cnt=%0d pass=%0d", tag, s, n, o_vc, o_ec, o_pass);
    stim_v.delete(); stim_in.delete(); stim_bad.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_vec_cnt"}, o_vc, 0);
    check({tag, "_err_cnt"}, o_ec, 0);
    check({tag, "_first_in"}, o_fi, 0);
    check({tag, "_first_out"}, o_fo, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_zero($sformatf("reset%0d", s));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Correct inverter, then two corrupted responses.
    add(1, 0, 0); add(1, 1, 0); add(1, 2, 0); add(1, 15, 0); add(1, 14, 0);
    run_check("t1", 0, 5, 2);
    add(1, 0, 0); add(1, 1, 0); add(1, 2, 4'd15); add(1, 15, 0); add(1, 14, 4'd1);
    run_check("t2", 0, 5, 2);

    // Two-stage DUT, then one stage short.
    add(1, 5, 0); add(1, 10, 0); add(1, 0, 0);
    run_check("t3a", 1, 3, 2);
    add(1, 5, 0); add(1, 10, 0); add(1, 0, 0);
    run_check("t3b", 1, 3, 1);

    // Empty run; valid pulses in DONE must not count.
    add(1, 3, 0); add(0, 9, 0); add(1, 7, 4'd4);
    run_check("t4", 0, 0, 2);

    // Narrow counters, every vector wrong, extra vectors beyond num_vec.
    add(1, 1, 4'd3); add(1, 6, 4'd8); add(1, 9, 4'd1); add(1, 4, 4'd2); add(1, 12, 4'd5);
    run_check("t5", 2, 3, 2);

    // Reset in the middle of a run.
    sel = 0;
    @(negedge clk);
    start = 1'b1; num_vec = 8'd5;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b1; a_in = 4'd1; a_bad = '0;
    @(negedge clk);
    a_in = 4'd2;
    @(negedge clk);
    check("t6_pre_vec_cnt", o_vc, 2);
    check("t6_pre_busy", o_busy, 1);
    vec_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) add(1, 4'($urandom_range(0, 15)), 0);
    run_check("t6_rerun", 0, 5, 2);

    // Randomized runs across all three instances.
    for (int r = 0; r < 18; r++) begin
      int s = r % 3;
      int n = (s == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 8));
      int k = int'($urandom_range(1, 2));
      int target = n + int'($urandom_range(0, 2));
      int got = 0;
      while (got < target) begin
        bit v = ($urandom % 4) != 0;
        logic [3:0] bad = (($urandom % 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        add(v, 4'($urandom_range(0, 15)), bad);
        if (v) got++;
      end
      run_check($sformatf("rnd%0d", r), s, n, k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
